// File: rtl/sig_gen_sweep_pkg.sv
// Shared state encoding and default widths for the sig_gen Doppler sweep controller.
package sig_gen_sweep_pkg;

  localparam int unsigned DEF_PHASE_BITS     = 32;
  localparam int unsigned DEF_N_BITS         = 16;
  localparam int unsigned DEF_BIN_BITS       = 10;
  localparam int unsigned DEF_SAMPLE_BITS    = 16;
  localparam int unsigned DEF_SETTLE_SAMPLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_e;

endpackage

// File: rtl/sweep_bin_counter.sv
// Bin index, freq_step accumulator and last-bin compare for one sweep.
module sweep_bin_counter
  import sig_gen_sweep_pkg::*;
#(
  parameter int unsigned PHASE_BITS = DEF_PHASE_BITS,
  parameter int unsigned BIN_BITS   = DEF_BIN_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [PHASE_BITS-1:0] cfg_freq_start,
  input  logic [PHASE_BITS-1:0] cfg_freq_incr,
  input  logic [BIN_BITS-1:0]   cfg_num_bins,
  output logic [PHASE_BITS-1:0] freq_step,
  output logic [BIN_BITS-1:0]   bin,
  output logic                  last_bin
);

  logic [BIN_BITS-1:0]   bin_q, bin_d;
  logic [BIN_BITS-1:0]   last_idx_q, last_idx_d;
  logic [PHASE_BITS-1:0] freq_q, freq_d;
  logic [PHASE_BITS-1:0] incr_q, incr_d;

  // Latch the sweep on load; step bin and phase increment on advance (wraps modulo 2^PHASE_BITS).
  always_comb begin
    bin_d      = bin_q;
    last_idx_d = last_idx_q;
    freq_d     = freq_q;
    incr_d     = incr_q;
    if (load) begin
      bin_d      = '0;
      last_idx_d = cfg_num_bins - BIN_BITS'(1);
      freq_d     = cfg_freq_start;
      incr_d     = cfg_freq_incr;
    end else if (advance) begin
      bin_d  = bin_q + BIN_BITS'(1);
      freq_d = freq_q + incr_q;
    end else begin
      bin_d  = bin_q;
      freq_d = freq_q;
    end
  end

  // Register stage for the sweep bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q      <= '0;
      last_idx_q <= '0;
      freq_q     <= '0;
      incr_q     <= '0;
    end else begin
      bin_q      <= bin_d;
      last_idx_q <= last_idx_d;
      freq_q     <= freq_d;
      incr_q     <= incr_d;
    end
  end

  assign freq_step = freq_q;
  assign bin       = bin_q;
  assign last_bin  = (bin_q == last_idx_q);

endmodule

// File: rtl/sig_gen_sweep_ctrl.sv
// Steps sig_gen through a sweep of Doppler bins: retune, drop settling samples,
// then forward samples_per_bin tagged cosine/sine samples per bin.
module sig_gen_sweep_ctrl
  import sig_gen_sweep_pkg::*;
#(
  parameter int unsigned PHASE_BITS     = DEF_PHASE_BITS,
  parameter int unsigned N_BITS         = DEF_N_BITS,
  parameter int unsigned BIN_BITS       = DEF_BIN_BITS,
  parameter int unsigned SAMPLE_BITS    = DEF_SAMPLE_BITS,
  parameter int unsigned SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_BITS-1:0]  cfg_freq_start,
  input  logic [PHASE_BITS-1:0]  cfg_freq_incr,
  input  logic [BIN_BITS-1:0]    cfg_num_bins,
  input  logic [SAMPLE_BITS-1:0] cfg_samples_per_bin,
  output logic [PHASE_BITS-1:0]  freq_step,
  output logic                   m_axis_freq_step_tvalid,
  input  logic                   m_axis_freq_step_tready,
  input  logic                   s_axis_data_tvalid,
  output logic                   m_axis_data_tready,
  output logic                   out_tvalid,
  input  logic                   out_tready,
  output logic [BIN_BITS-1:0]    out_bin,
  output logic                   out_last,
  output logic                   busy,
  output logic                   bin_done,
  output logic                   sweep_done,
  output logic                   cfg_err
);

  localparam logic [SAMPLE_BITS-1:0] SETTLE_LAST = SAMPLE_BITS'(SETTLE_SAMPLES - 1);
  localparam bit                     HAS_SETTLE  = (SETTLE_SAMPLES != 0);

  // Samples themselves bypass this block; N_BITS only documents sig_gen's width.
  if (N_BITS == 0) begin : g_zero_width_samples
  end

  sweep_state_e           state_q, state_d;
  logic [SAMPLE_BITS-1:0] count_q, count_d;
  logic [SAMPLE_BITS-1:0] spb_last_q, spb_last_d;
  logic                   bin_done_q, bin_done_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   load_s, advance_s, last_bin_s, taken_s, cfg_ok_s;

  sweep_bin_counter #(
    .PHASE_BITS (PHASE_BITS),
    .BIN_BITS   (BIN_BITS)
  ) u_bin_counter (
    .clk            (clk),
    .reset          (reset),
    .load           (load_s),
    .advance        (advance_s),
    .cfg_freq_start (cfg_freq_start),
    .cfg_freq_incr  (cfg_freq_incr),
    .cfg_num_bins   (cfg_num_bins),
    .freq_step      (freq_step),
    .bin            (out_bin),
    .last_bin       (last_bin_s)
  );

  assign m_axis_data_tready      = (state_q == ST_SETTLE) | ((state_q == ST_RUN) & out_tready);
  assign out_tvalid              = (state_q == ST_RUN) & s_axis_data_tvalid;
  assign out_last                = (state_q == ST_RUN) & (count_q == spb_last_q);
  assign m_axis_freq_step_tvalid = (state_q == ST_LOAD);
  assign busy                    = (state_q != ST_IDLE);
  assign sweep_done              = (state_q == ST_DONE);
  assign bin_done                = bin_done_q;
  assign cfg_err                 = cfg_err_q;

  assign taken_s  = s_axis_data_tvalid & m_axis_data_tready;
  assign cfg_ok_s = (cfg_num_bins != '0) && (cfg_samples_per_bin != '0);

  // Next-state, counter and pulse logic; abort outranks start and bin completion.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    spb_last_d = spb_last_q;
    bin_done_d = 1'b0;
    cfg_err_d  = 1'b0;
    load_s     = 1'b0;
    advance_s  = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            if (cfg_ok_s) begin
              load_s     = 1'b1;
              spb_last_d = cfg_samples_per_bin - SAMPLE_BITS'(1);
              count_d    = '0;
              state_d    = ST_LOAD;
            end else begin
              cfg_err_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (m_axis_freq_step_tready) begin
            count_d = '0;
            state_d = HAS_SETTLE ? ST_SETTLE : ST_RUN;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_SETTLE: begin
          if (taken_s && (count_q == SETTLE_LAST)) begin
            count_d = '0;
            state_d = ST_RUN;
          end else if (taken_s) begin
            count_d = count_q + SAMPLE_BITS'(1);
          end else begin
            count_d = count_q;
          end
        end
        ST_RUN: begin
          if (taken_s && (count_q == spb_last_q)) begin
            count_d    = '0;
            bin_done_d = 1'b1;
            if (last_bin_s) begin
              state_d = ST_DONE;
            end else begin
              advance_s = 1'b1;
              state_d   = ST_LOAD;
            end
          end else if (taken_s) begin
            count_d = count_q + SAMPLE_BITS'(1);
          end else begin
            count_d = count_q;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      spb_last_q <= '0;
      bin_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      spb_last_q <= spb_last_d;
      bin_done_q <= bin_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

endmodule
